// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers: 32-step radix-2 shift-add / restoring divide.
// Optional pipeline-flush abort is compiled in with `define MDU_CANCEL_EN (adds the cancel port).
module mdu_iterative #(
    parameter int         WIDTH    = 32,
    parameter logic [1:0] OP_MULT  = 2'b00,
    parameter logic [1:0] OP_MULTU = 2'b01,
    parameter logic [1:0] OP_DIV   = 2'b10,
    parameter logic [1:0] OP_DIVU  = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return neg_w(v);
        end else begin
            return v;
        end
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 div_q, div_d;
    logic                 div0_q, div0_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     a_orig_q, a_orig_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 cancel_s;
    logic                 is_signed_s;
    logic                 is_div_s;
    logic [WIDTH-1:0]     a_abs_s;
    logic [WIDTH-1:0]     b_abs_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_rem_sh_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_sub_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

`ifdef MDU_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    assign is_signed_s = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_s    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_abs_s     = abs_w(a, is_signed_s);
    assign b_abs_s     = abs_w(b, is_signed_s);

    // Multiply step: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
    assign mul_next_s = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring divide step: remainder in the high half, dividend shifts out as quotient bits shift in.
    assign div_rem_sh_s = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge_s     = (div_rem_sh_s >= {1'b0, dvs_q});
    assign div_sub_s    = div_rem_sh_s[WIDTH-1:0] - dvs_q;
    assign div_next_s   = div_ge_s ? {div_sub_s, acc_q[WIDTH-2:0], 1'b1}
                                   : {div_rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_s = neg_res_q ? neg_2w(acc_q) : acc_q;

    // Sign correction and divide-by-zero override for the FIX write.
    always_comb begin
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (div_q) begin
            if (div0_q) begin
                fix_hi_s = a_orig_q;
                fix_lo_s = ONES_W;
            end else begin
                fix_hi_s = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                fix_lo_s = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_orig_d  = a_orig_q;
        dvs_d     = dvs_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) begin
                    hi_d = wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (start) begin
                    state_d   = ST_CALC;
                    cnt_d     = CNT_ZERO;
                    busy_d    = 1'b1;
                    div_d     = is_div_s;
                    div0_d    = is_div_s && (b == ZERO_W);
                    neg_res_d = is_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed_s && a[WIDTH-1];
                    a_orig_d  = a;
                    dvs_d     = is_div_s ? b_abs_s : a_abs_s;
                    acc_d     = {ZERO_W, (is_div_s ? a_abs_s : b_abs_s)};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cancel_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = div_q ? div_next_s : mul_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (cancel_s) begin
                    done_d = 1'b0;
                end else begin
                    hi_d   = fix_hi_s;
                    lo_d   = fix_lo_s;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            div_q     <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_orig_q  <= ZERO_W;
            dvs_q     <= ZERO_W;
            acc_q     <= {ZERO_W, ZERO_W};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_orig_q  <= a_orig_d;
            dvs_q     <= dvs_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: cycle-level behavioural model plus directed literal pins and random ops.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n, start, hi_we, lo_we, cancel;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    logic        m_busy, m_done;
    int          m_left;
    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    int          busy_cnt;

    always #5 clk = ~clk;

    mdu_iterative dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Reference result from plain 64-bit arithmetic.
    task automatic calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sx, sy, p, q, r;
        logic        [63:0] u;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            2'b01: begin u = {32'd0, x} * {32'd0, y}; h = u[63:32]; l = u[31:0]; end
            2'b10: begin
                if (y == 32'd0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            end
            default: begin
                if (y == 32'd0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin h = x % y; l = x / y; end
            end
        endcase
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
    task automatic step();
        logic done_n;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            done_n = 1'b0;
            if (m_busy) begin
                if (cancel) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; done_n = 1'b1;
                    end
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    calc(op, a, b, r_hi, r_lo);
                    m_busy = 1'b1;
                    m_left = 33;
                end
            end
            m_done = done_n;
        end
        #1;
        check32("busy", {31'd0, busy}, {31'd0, m_busy});
        check32("done", {31'd0, done}, {31'd0, m_done});
        check32("hi", hi, m_hi);
        check32("lo", lo, m_lo);
        if (busy) busy_cnt++;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        busy_cnt = 0;
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        repeat (33) step();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
        op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
        model_reset();
        busy_cnt = 0;
        step();
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_hi", hi, 32'd0);
        rst_n = 1'b1;
        step();

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check32("multu_busycycles", busy_cnt, 32'd33);
        check32("multu_done", {31'd0, done}, 32'd1);
        check32("multu_hi", hi, 32'hFFFF_FFFE);
        check32("multu_lo", lo, 32'h0000_0001);
        step();
        check32("done_once", {31'd0, done}, 32'd0);

        do_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFF1);
        do_op(2'b11, 32'd7, 32'd2);
        check32("divu_lo", lo, 32'd3);
        check32("divu_hi", hi, 32'd1);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        check32("div_neg_lo", lo, 32'hFFFF_FFFD);
        check32("div_neg_hi", hi, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check32("div_ovf_lo", lo, 32'h8000_0000);
        check32("div_ovf_hi", hi, 32'd0);
        do_op(2'b10, 32'h0000_1234, 32'd0);
        check32("div0_hi", hi, 32'h0000_1234);
        check32("div0_lo", lo, 32'hFFFF_FFFF);
        step();

        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        step();
        hi_we = 1'b0;
        check32("mthi_hi", hi, 32'hA5A5_A5A5);
        check32("mthi_nodone", {31'd0, done}, 32'd0);

        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        check32("ignored_start_lo", lo, 32'd6);
        check32("ignored_start_hi", hi, 32'd0);

        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check32("async_rst_busy", {31'd0, busy}, 32'd0);
        check32("async_rst_done", {31'd0, done}, 32'd0);
        check32("async_rst_lo", lo, 32'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        step();

`ifdef MDU_CANCEL_EN
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check32("cancel_busy", {31'd0, busy}, 32'd0);
        check32("cancel_hi", hi, 32'h1234_5678);
        check32("cancel_lo", lo, 32'h1234_5678);
        step();
        check32("cancel_nodone", {31'd0, done}, 32'd0);
        op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        check32("cancel_idle_start", {31'd0, busy}, 32'd1);
        repeat (33) step();
        check32("cancel_idle_lo", lo, 32'd12);
`endif

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                hi_we = ($urandom_range(0, 3) == 0); lo_we = ($urandom_range(0, 3) == 0);
                wdata = $urandom;
                step();
            end
            hi_we = ($urandom_range(0, 5) == 0); lo_we = 1'b0; wdata = $urandom;
            op = 2'($urandom_range(0, 3)); a = pick(); b = pick(); start = 1'b1;
            step();
            for (int c = 0; c < 33; c++) begin
                start = ($urandom_range(0, 7) == 0);
                op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
                hi_we = ($urandom_range(0, 7) == 0); lo_we = ($urandom_range(0, 7) == 0);
                wdata = $urandom;
                if (c == 32) start = 1'b0;
                step();
            end
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        end
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
